evm_session_controller: RTL and testbench
=========================================

# evm_session_controller

Sequencing controller for the EVM ID database. It authenticates the polling officer, presents voter IDs to the combinational ID database, and blocks duplicate votes with a per-address voted bitmap. It captures one candidate selection per verified voter, with a timeout, and keeps saturating per-candidate tallies. It sits between the ballot/officer keypad front end and the ID database, and drives the database's mode, control and ID inputs.

## Interface
- WORD_SIZE, 5, ID width; matches the database.
- ADDRESS_SIZE, 4, voter address width; the voted bitmap has 2**ADDRESS_SIZE bits.
- NUM_CAND, 4, number of candidates (2..8).
- COUNT_WIDTH, 8, tally and total counter width.
- TIMEOUT, 16, cycles allowed for a vote after voter acceptance (≥2).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_in  in  WORD_SIZE  keypad ID; sampled when id_valid=1.
- id_valid  in  1  one-cycle ID strobe.
- end_req  in  1  one-cycle end-of-session strobe.
- cand_sel  in  NUM_CAND  one-hot candidate button vector.
- cand_valid  in  1  one-cycle vote strobe.
- tally_sel  in  $clog2(NUM_CAND)  tally read index.
- db_officer_ok, db_reset_ok, db_voter_ok  in  1 each  database status flags.
- db_voter_addr  in  ADDRESS_SIZE  database matched-voter address.
- db_id  out  WORD_SIZE  registered ID; wired to the database officer_id, voter_id and reset_id ports.
- db_mode, db_control  out  1 each  database enables.
- session_open  out  1  high in READY, CHECK, WAIT_VOTE and COMMIT.
- vote_wait  out  1  high in WAIT_VOTE.
- vote_accepted  out  1  one-cycle pulse on commit.
- reject  out  1  one-cycle pulse on any rejection.
- reject_code  out  3  last rejection reason; held until the next rejection.
- reset_done  out  1  one-cycle pulse after a tally clear.
- tally_out  out  COUNT_WIDTH  tally[tally_sel]; combinational read; 0 if index ≥ NUM_CAND.
- total_votes  out  COUNT_WIDTH  accepted votes since clear; saturating.

## Operation
- States: IDLE, AUTH, READY, CHECK, WAIT_VOTE, COMMIT. db_mode and db_control are Moore outputs, both 1 only in AUTH and CHECK. Database status inputs are sampled only in those states.
- **IDLE:** on id_valid, db_id ← id_in and go to AUTH. end_req is ignored.
- **AUTH:**
  - db_officer_ok=1: go to READY.
  - Otherwise: reject, code 1 (BAD_OFFICER), go to IDLE.
- **READY:**
  - end_req: go to IDLE; tallies, bitmap and total are retained. end_req has priority over a simultaneous id_valid.
  - id_valid: db_id ← id_in, go to CHECK.
- **CHECK** (priority order):
  1. db_reset_ok: clear all tallies, total_votes and the bitmap; pulse reset_done; go to READY.
  2. db_voter_ok and voted[db_voter_addr]=0: latch the address, go to WAIT_VOTE.
  3. db_voter_ok and voted[db_voter_addr]=1: reject, code 3 (DUPLICATE), go to READY.
  4. Otherwise: reject, code 2 (UNKNOWN_VOTER), go to READY. The officer ID presented here falls into this case.
- **WAIT_VOTE:**
  - Timer clears on entry.
  - cand_valid with exactly one bit set: latch the candidate index, go to COMMIT.
  - cand_valid with zero or multiple bits set: reject, code 4 (BAD_CAND), stay in WAIT_VOTE; the timer continues.
  - No commit by the TIMEOUT-th cycle in WAIT_VOTE: reject, code 5 (TIMEOUT), go to READY; the voter is not marked.
  - id_valid and end_req are ignored.
- **COMMIT:** increment tally[idx] (saturates at 2**COUNT_WIDTH-1), increment total_votes (saturates), set voted[addr], pulse vote_accepted, go to READY.
- Reset values: state=IDLE; all outputs 0 (db_id=0, reject_code=0); tallies, total and bitmap all 0.
- Reset mid-operation (any state, including COMMIT): immediate return to reset values; a pending vote is lost.

## Timing
- id_valid in READY at cycle N: CHECK at N+1 (db_id and enables valid, database settles combinationally). Next state or reject pulse at N+2.
- Officer authentication has the same 2-cycle latency from id_valid to session_open=1.
- cand_valid at cycle M: COMMIT at M+1. vote_accepted, updated tally_out and updated total_votes are visible at M+2. Voter to READY at M+2.
- Timeout: WAIT_VOTE is entered at cycle T. With no valid vote, the reject pulse is asserted in cycle T+TIMEOUT-1 and READY is reached at T+TIMEOUT.
- A cand_valid arriving in the final WAIT_VOTE cycle commits; the vote wins over the timeout.
- Inputs are accepted only in the states listed above; strobes in other states are dropped without a response.

## Test plan
- **Officer login and voting:** id_in=5'b11111 in IDLE → session_open=1 two cycles later. Voter 5'b00011 then cand_sel=4'b0100 → vote_accepted; tally_sel=2 reads 1; total_votes=1.
- **Bad officer:** id_in=5'b00101 in IDLE → reject, reject_code=1, state stays IDLE, db_mode=0 afterwards.
- **Duplicate:** voter 5'b00011 votes, then presents again → reject_code=3; tallies unchanged.
- **Unknown voter and bad candidate:** id_in=5'b10101 → reject_code=2. Valid voter with cand_sel=4'b0110 → reject_code=4, still in WAIT_VOTE; a following 4'b0001 commits to tally 0.
- **Timeout:** valid voter with no cand_valid for 16 cycles → reject_code=5, READY; the same voter can then vote successfully.
- **Reset ID and async reset:** id_in=5'b11110 in READY → reset_done, all tallies 0, bitmap cleared (a prior voter may vote again). rst_n low during COMMIT → tally not incremented, state IDLE, all outputs 0.

Source files
------------

// File: rtl/evm_session_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// evm_session_controller - officer login, voter check, vote capture, tallies
// Revision: 1.0
// ----------------------------------------------------------------------------
module evm_session_controller #(
  parameter int WORD_SIZE    = 5,
  parameter int ADDRESS_SIZE = 4,
  parameter int NUM_CAND     = 4,
  parameter int COUNT_WIDTH  = 8,
  parameter int TIMEOUT      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WORD_SIZE-1:0]        id_in,
  input  logic                        id_valid,
  input  logic                        end_req,
  input  logic [NUM_CAND-1:0]         cand_sel,
  input  logic                        cand_valid,
  input  logic [$clog2(NUM_CAND)-1:0] tally_sel,
  input  logic                        db_officer_ok,
  input  logic                        db_reset_ok,
  input  logic                        db_voter_ok,
  input  logic [ADDRESS_SIZE-1:0]     db_voter_addr,
  output logic [WORD_SIZE-1:0]        db_id,
  output logic                        db_mode,
  output logic                        db_control,
  output logic                        session_open,
  output logic                        vote_wait,
  output logic                        vote_accepted,
  output logic                        reject,
  output logic [2:0]                  reject_code,
  output logic                        reset_done,
  output logic [COUNT_WIDTH-1:0]      tally_out,
  output logic [COUNT_WIDTH-1:0]      total_votes
);

  localparam int SEL_W = $clog2(NUM_CAND);
  localparam int TMR_W = $clog2(TIMEOUT);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_AUTH   = 3'd1;
  localparam logic [2:0] ST_READY  = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_COMMIT = 3'd5;

  localparam logic [2:0] RC_BAD_OFFICER = 3'd1;
  localparam logic [2:0] RC_UNKNOWN     = 3'd2;
  localparam logic [2:0] RC_DUPLICATE   = 3'd3;
  localparam logic [2:0] RC_BAD_CAND    = 3'd4;
  localparam logic [2:0] RC_TIMEOUT     = 3'd5;

  localparam logic [TMR_W-1:0]       TMR_WARN = TMR_W'(TIMEOUT - 2);
  localparam logic [TMR_W-1:0]       TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [2:0]              state_q, state_d;
  logic [WORD_SIZE-1:0]    db_id_q, db_id_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]        idx_q, idx_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic                    reject_q, reject_d;
  logic [2:0]              code_q, code_d;
  logic                    rdone_q, rdone_d;
  logic                    acc_q, acc_d;
  logic                    clear_all, commit;

  logic [COUNT_WIDTH-1:0]        tally_q [NUM_CAND];
  logic [COUNT_WIDTH-1:0]        total_q;
  logic [(2**ADDRESS_SIZE)-1:0]  voted_q;

  logic             cand_onehot;
  logic [SEL_W-1:0] cand_idx;

  always_comb begin
    cand_onehot = ($countones(cand_sel) == 1);
    cand_idx    = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (cand_sel[i]) cand_idx = SEL_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    db_id_d   = db_id_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    reject_d  = 1'b0;
    code_d    = code_q;
    rdone_d   = 1'b0;
    acc_d     = 1'b0;
    clear_all = 1'b0;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (id_valid) begin
          db_id_d = id_in;
          state_d = ST_AUTH;
        end
      end
      ST_AUTH: begin
        if (db_officer_ok) begin
          state_d = ST_READY;
        end else begin
          reject_d = 1'b1;
          code_d   = RC_BAD_OFFICER;
          state_d  = ST_IDLE;
        end
      end
      ST_READY: begin
        if (end_req) begin
          state_d = ST_IDLE;
        end else if (id_valid) begin
          db_id_d = id_in;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (db_reset_ok) begin
          clear_all = 1'b1;
          rdone_d   = 1'b1;
          state_d   = ST_READY;
        end else if (db_voter_ok && !voted_q[db_voter_addr]) begin
          addr_d  = db_voter_addr;
          timer_d = '0;
          state_d = ST_WAIT;
        end else if (db_voter_ok) begin
          reject_d = 1'b1;
          code_d   = RC_DUPLICATE;
          state_d  = ST_READY;
        end else begin
          reject_d = 1'b1;
          code_d   = RC_UNKNOWN;
          state_d  = ST_READY;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (cand_valid && cand_onehot) begin
          idx_d   = cand_idx;
          state_d = ST_COMMIT;
        end else begin
          if (cand_valid) begin
            reject_d = 1'b1;
            code_d   = RC_BAD_CAND;
          end
          // Timeout pulse is registered so it lands in the last waiting cycle
          if (timer_q == TMR_WARN) begin
            reject_d = 1'b1;
            code_d   = RC_TIMEOUT;
          end
          if (timer_q == TMR_LAST) state_d = ST_READY;
        end
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        acc_d   = 1'b1;
        state_d = ST_READY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      db_id_q  <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      timer_q  <= '0;
      reject_q <= 1'b0;
      code_q   <= 3'd0;
      rdone_q  <= 1'b0;
      acc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_id_q  <= db_id_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      reject_q <= reject_d;
      code_q   <= code_d;
      rdone_q  <= rdone_d;
      acc_q    <= acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
      total_q <= '0;
      voted_q <= '0;
    end else if (clear_all) begin
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
      total_q <= '0;
      voted_q <= '0;
    end else if (commit) begin
      if (tally_q[idx_q] != CNT_MAX) tally_q[idx_q] <= tally_q[idx_q] + 1'b1;
      if (total_q != CNT_MAX) total_q <= total_q + 1'b1;
      voted_q[addr_q] <= 1'b1;
    end
  end

  always_comb begin
    tally_out = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (tally_sel == SEL_W'(i)) tally_out = tally_q[i];
    end
  end

  assign db_id         = db_id_q;
  assign db_mode       = (state_q == ST_AUTH) || (state_q == ST_CHECK);
  assign db_control    = db_mode;
  assign session_open  = (state_q == ST_READY) || (state_q == ST_CHECK) ||
                         (state_q == ST_WAIT)  || (state_q == ST_COMMIT);
  assign vote_wait     = (state_q == ST_WAIT);
  assign vote_accepted = acc_q;
  assign reject        = reject_q;
  assign reject_code   = code_q;
  assign reset_done    = rdone_q;
  assign total_votes   = total_q;

endmodule
`default_nettype wire

// File: tb/tb_evm_session_controller.sv
`default_nettype none
// tb_evm_session_controller: randomized session traffic checked against a
// tally/bitmap reference model; a tiny ID database model answers the DUT.
module tb_evm_session_controller;

  localparam int WS = 5;
  localparam int AS = 4;
  localparam int NC = 4;
  localparam int CW = 8;
  localparam int TO = 16;

  localparam logic [WS-1:0] OFFICER_ID = 5'b11111;
  localparam logic [WS-1:0] RESET_ID   = 5'b11110;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [WS-1:0] id_in = '0;
  logic          id_valid = 1'b0;
  logic          end_req = 1'b0;
  logic [NC-1:0] cand_sel = '0;
  logic          cand_valid = 1'b0;
  logic [1:0]    tally_sel = '0;
  logic          db_officer_ok, db_reset_ok, db_voter_ok;
  logic [AS-1:0] db_voter_addr;
  logic [WS-1:0] db_id;
  logic          db_mode, db_control, session_open, vote_wait;
  logic          vote_accepted, reject, reset_done;
  logic [2:0]    reject_code;
  logic [CW-1:0] tally_out, total_votes;

  evm_session_controller #(
    .WORD_SIZE(WS), .ADDRESS_SIZE(AS), .NUM_CAND(NC), .COUNT_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_in(id_in), .id_valid(id_valid), .end_req(end_req),
    .cand_sel(cand_sel), .cand_valid(cand_valid), .tally_sel(tally_sel),
    .db_officer_ok(db_officer_ok), .db_reset_ok(db_reset_ok), .db_voter_ok(db_voter_ok),
    .db_voter_addr(db_voter_addr), .db_id(db_id), .db_mode(db_mode), .db_control(db_control),
    .session_open(session_open), .vote_wait(vote_wait), .vote_accepted(vote_accepted),
    .reject(reject), .reject_code(reject_code), .reset_done(reset_done),
    .tally_out(tally_out), .total_votes(total_votes)
  );

  always #5 clk = ~clk;

  // Database: voters are IDs 1..15 at address id[3:0]; answers only when enabled
  logic db_en;
  assign db_en         = db_mode & db_control;
  assign db_officer_ok = db_en && (db_id == OFFICER_ID);
  assign db_reset_ok   = db_en && (db_id == RESET_ID);
  assign db_voter_ok   = db_en && !db_id[4] && (db_id != '0);
  assign db_voter_addr = db_id[3:0];

  int n_checks = 0;
  int n_fail   = 0;
  int m_tally[NC];
  int m_total;
  bit m_voted[16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_voter(input logic [WS-1:0] id);
    return !id[4] && (id != '0);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NC; i++) m_tally[i] = 0;
    m_total = 0;
    for (int i = 0; i < 16; i++) m_voted[i] = 1'b0;
  endtask

  task automatic check_tallies(input string tag);
    for (int i = 0; i < NC; i++) begin
      tally_sel = 2'(i);
      #1;
      check($sformatf("%s_tally%0d", tag, i), 32'(tally_out), 32'(m_tally[i]));
    end
    check({tag, "_total"}, 32'(total_votes), 32'(m_total));
  endtask

  task automatic login(input logic [WS-1:0] oid);
    bit good;
    good = (oid == OFFICER_ID);
    id_in = oid; id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    check("auth_enables", {30'd0, db_mode, db_control}, 32'd3);
    check("auth_not_open", 32'(session_open), 32'd0);
    tick();
    if (good) begin
      check("login_open", 32'(session_open), 32'd1);
      check("login_no_reject", 32'(reject), 32'd0);
    end else begin
      check("badoff_reject", 32'(reject), 32'd1);
      check("badoff_code", 32'(reject_code), 32'd1);
      check("badoff_closed", 32'(session_open), 32'd0);
      tick();
      check("badoff_mode_off", 32'(db_mode), 32'd0);
      check("badoff_pulse_end", 32'(reject), 32'd0);
    end
  endtask

  task automatic present_id(input logic [WS-1:0] vid, output bit acc);
    id_in = vid; id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    check("check_db_id", 32'(db_id), 32'(vid));
    check("check_mode", 32'(db_mode), 32'd1);
    tick();
    acc = 1'b0;
    if (vid == RESET_ID) begin
      check("clear_done", 32'(reset_done), 32'd1);
      check("clear_ready", 32'(session_open & ~vote_wait), 32'd1);
      model_clear();
      check_tallies("clear");
    end else if (is_voter(vid) && !m_voted[vid[3:0]]) begin
      check("voter_wait", 32'(vote_wait), 32'd1);
      check("voter_no_reject", 32'(reject), 32'd0);
      acc = 1'b1;
    end else if (is_voter(vid)) begin
      check("dup_reject", 32'(reject), 32'd1);
      check("dup_code", 32'(reject_code), 32'd3);
      check("dup_ready", 32'(vote_wait), 32'd0);
    end else begin
      check("unk_reject", 32'(reject), 32'd1);
      check("unk_code", 32'(reject_code), 32'd2);
      check("unk_ready", 32'(session_open & ~vote_wait), 32'd1);
    end
  endtask

  // kind 0: vote at cycle d1; kind 1: bad selection at d1 then vote at d2; kind 2: timeout
  task automatic vote_phase(input logic [AS-1:0] addr, input int kind, input int d1,
                            input int d2, input int cand);
    int k;
    logic [NC-1:0] bad;
    k = 0;
    if (kind == 2) begin
      while (k < TO - 2) begin tick(); k++; end
      check("to_early_reject", 32'(reject), 32'd0);
      tick(); k++;
      check("to_reject", 32'(reject), 32'd1);
      check("to_code", 32'(reject_code), 32'd5);
      check("to_still_wait", 32'(vote_wait), 32'd1);
      tick();
      check("to_ready", 32'(session_open & ~vote_wait), 32'd1);
      check("to_total", 32'(total_votes), 32'(m_total));
    end else begin
      if (kind == 1) begin
        while (k < d1) begin tick(); k++; end
        do bad = NC'($urandom_range(0, 15)); while ($countones(bad) == 1);
        cand_sel = bad; cand_valid = 1'b1;
        tick(); k++;
        cand_valid = 1'b0;
        check("badcand_reject", 32'(reject), 32'd1);
        check("badcand_code", 32'(reject_code), 32'd4);
        check("badcand_wait", 32'(vote_wait), 32'd1);
      end else begin
        d2 = d1;
      end
      while (k < d2) begin tick(); k++; end
      cand_sel = NC'(1 << cand); cand_valid = 1'b1;
      tick();
      cand_valid = 1'b0;
      check("commit_phase", {30'd0, session_open, vote_wait}, 32'd2);
      tick();
      check("vote_accepted", 32'(vote_accepted), 32'd1);
      if (m_tally[cand] < 255) m_tally[cand]++;
      if (m_total < 255) m_total++;
      m_voted[addr] = 1'b1;
      tally_sel = 2'(cand);
      #1;
      check("vote_tally", 32'(tally_out), 32'(m_tally[cand]));
      check("vote_total", 32'(total_votes), 32'(m_total));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acc;
    int r, kind, d1, d2, c;
    logic [WS-1:0] vid;
    model_clear();

    // reset state
    repeat (3) tick();
    check("rst_db_id", 32'(db_id), 32'd0);
    check("rst_open", 32'(session_open), 32'd0);
    check("rst_code", 32'(reject_code), 32'd0);
    check("rst_mode", 32'(db_mode), 32'd0);
    check_tallies("rst");
    rst_n = 1'b1;
    tick();

    end_req = 1'b1; tick(); end_req = 1'b0;
    check("idle_endreq_ignored", 32'(db_mode | session_open), 32'd0);

    login(5'b00101);
    login(OFFICER_ID);

    present_id(5'b00011, acc);
    if (acc) vote_phase(4'd3, 0, 2, 0, 2);
    present_id(5'b00011, acc);
    check_tallies("dup");
    present_id(5'b10101, acc);
    present_id(OFFICER_ID, acc);
    present_id(5'b00101, acc);
    if (acc) vote_phase(4'd5, 1, 1, 4, 0);
    present_id(5'b00110, acc);
    if (acc) vote_phase(4'd6, 2, 0, 0, 0);
    present_id(5'b00110, acc);
    if (acc) vote_phase(4'd6, 0, 3, 0, 1);
    present_id(5'b00111, acc);
    if (acc) vote_phase(4'd7, 0, TO - 1, 0, 3);
    check_tallies("directed");

    present_id(RESET_ID, acc);
    present_id(5'b00011, acc);
    check("revote_after_clear", 32'(acc), 32'd1);
    if (acc) vote_phase(4'd3, 0, 0, 0, 1);

    // end_req wins over a simultaneous id_valid
    end_req = 1'b1; id_valid = 1'b1; id_in = 5'b00100;
    tick();
    end_req = 1'b0; id_valid = 1'b0;
    check("end_closed", 32'(session_open | db_mode), 32'd0);
    login(OFFICER_ID);
    check_tallies("end_retained");

    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        present_id(RESET_ID, acc);
      end else if (r < 10) begin
        end_req = 1'b1; tick(); end_req = 1'b0;
        check("rnd_end_closed", 32'(session_open), 32'd0);
        if ($urandom_range(0, 1) == 1) login(5'(2 * $urandom_range(0, 14) + 1));
        login(OFFICER_ID);
      end else begin
        if (r < 80) vid = 5'($urandom_range(1, 15));
        else        vid = 5'($urandom_range(0, 31));
        present_id(vid, acc);
        if (acc) begin
          r = $urandom_range(0, 99);
          kind = (r < 70) ? 0 : (r < 85) ? 1 : 2;
          d1 = $urandom_range(0, 12);
          d2 = $urandom_range(d1 + 1, 13);
          c  = $urandom_range(0, NC - 1);
          vote_phase(vid[3:0], kind, d1, d2, c);
        end
      end
      if (it % 25 == 24) check_tallies("rnd");
    end

    // asynchronous reset while in COMMIT
    present_id(RESET_ID, acc);
    present_id(5'b01001, acc);
    if (acc) vote_phase(4'd9, 0, 0, 0, 2);
    present_id(5'b01010, acc);
    check("pre_commit_accept", 32'(acc), 32'd1);
    cand_sel = 4'b0100; cand_valid = 1'b1;
    tick();
    cand_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_open", 32'(session_open), 32'd0);
    check("arst_accept", 32'(vote_accepted), 32'd0);
    check("arst_db_id", 32'(db_id), 32'd0);
    check("arst_code", 32'(reject_code), 32'd0);
    model_clear();
    check_tallies("arst");
    tick();
    rst_n = 1'b1;
    tick();
    check_tallies("arst_after");
    check("arst_idle", 32'(session_open | db_mode), 32'd0);
    login(OFFICER_ID);
    present_id(5'b01010, acc);
    check("arst_voter_unmarked", 32'(acc), 32'd1);
    if (acc) vote_phase(4'd10, 0, 1, 0, 3);
    check_tallies("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
